// File: rtl/hmc_test_pkg.sv
// ============================================================================
//  Module   : hmc_test_pkg
//  Purpose  : Shared PRBS definitions for the HMC test generator and checker.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package hmc_test_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HUNT   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam int          c_PRBS_SIZE = 15;
   localparam logic [14:0] c_PRBS_POLY = 15'b100000000000011;

endpackage

`default_nettype wire

// File: rtl/example_hmc_lfsr.sv
// ============================================================================
//  Module   : example_hmc_lfsr
//  Purpose  : Combinational multi-step LFSR: expected word and advanced state.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module example_hmc_lfsr
   import hmc_test_pkg::*;
#(
   parameter int                   DATA_WIDTH = 48,
   parameter int                   PRBS_SIZE  = c_PRBS_SIZE,
   parameter logic [PRBS_SIZE-1:0] PRBS_POLY  = c_PRBS_POLY
) (
   input  logic [PRBS_SIZE-1:0]  i_seed,
   output logic [DATA_WIDTH-1:0] o_exp_word,
   output logic [PRBS_SIZE-1:0]  o_next_state
);

   logic [PRBS_SIZE-1:0] w_state;

   // The window holds the next PRBS_SIZE bits, oldest in bit 0; the new bit
   // entering at the top is the tapped XOR of the current window.
   always_comb begin
      w_state    = i_seed;
      o_exp_word = '0;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         o_exp_word[i] = w_state[0];
         w_state       = {^(w_state & PRBS_POLY), w_state[PRBS_SIZE-1:1]};
      end
      o_next_state = w_state;
   end

endmodule

`default_nettype wire

// File: rtl/example_hmc_prbs_checker.sv
// ============================================================================
//  Module   : example_hmc_prbs_checker
//  Purpose  : Self-synchronising PRBS checker with lock FSM and error counters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module example_hmc_prbs_checker
   import hmc_test_pkg::*;
#(
   parameter int                   DATA_WIDTH = 48,
   parameter int                   PRBS_SIZE  = c_PRBS_SIZE,
   parameter logic [PRBS_SIZE-1:0] PRBS_POLY  = c_PRBS_POLY,
   parameter int                   LOCK_COUNT = 4,
   parameter int                   MISS_LIMIT = 4,
   parameter int                   CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  clear,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  locked,
   output logic                  word_err,
   output logic                  lock_lost,
   output logic [CNT_W-1:0]      word_cnt,
   output logic [CNT_W-1:0]      word_err_cnt,
   output logic [CNT_W-1:0]      bit_err_cnt
);

   localparam int         c_PC_W  = $clog2(DATA_WIDTH + 1);
   localparam int         c_SUM_W = ((CNT_W > c_PC_W) ? CNT_W : c_PC_W) + 1;
   localparam logic [3:0] c_LOCK  = 4'(LOCK_COUNT);
   localparam logic [3:0] c_MISS  = 4'(MISS_LIMIT);

   function automatic logic [c_PC_W-1:0] popcount(input logic [DATA_WIDTH-1:0] v);
      logic [c_PC_W-1:0] n;
      n = '0;
      for (int i = 0; i < DATA_WIDTH; i++) n = n + c_PC_W'(v[i]);
      return n;
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                input logic [c_PC_W-1:0] b);
      logic [c_SUM_W-1:0] s;
      s = c_SUM_W'(a) + c_SUM_W'(b);
      if (|s[c_SUM_W-1:CNT_W]) return '1;
      return s[CNT_W-1:0];
   endfunction

   state_t                r_state, w_state_nxt;
   logic [3:0]            r_good, w_good_nxt;
   logic [3:0]            r_miss, w_miss_nxt;
   logic [PRBS_SIZE-1:0]  r_lfsr, w_lfsr_nxt, w_seed, w_lfsr_adv;
   logic                  r_s1_valid;
   logic [DATA_WIDTH-1:0] r_s1_data;
   logic [DATA_WIDTH-1:0] w_exp, w_err_vec;
   logic                  w_mismatch, w_count, w_word_err, w_lost;
   logic                  r_word_err, r_lock_lost;
   logic                  r_s3_count, r_s3_err;
   logic [DATA_WIDTH-1:0] r_s3_vec;
   logic [CNT_W-1:0]      r_word_cnt, r_word_err_cnt, r_bit_err_cnt;

   // A fresh hunt (no clean words yet) seeds from the word itself; otherwise
   // the prediction continues from the held state.
   assign w_seed     = (r_state == HUNT && r_good == 4'd0) ? r_s1_data[PRBS_SIZE-1:0] : r_lfsr;
   assign w_err_vec  = r_s1_data ^ w_exp;
   assign w_mismatch = |w_err_vec;

   example_hmc_lfsr #(
      .DATA_WIDTH (DATA_WIDTH),
      .PRBS_SIZE  (PRBS_SIZE),
      .PRBS_POLY  (PRBS_POLY)
   ) u_lfsr (
      .i_seed       (w_seed),
      .o_exp_word   (w_exp),
      .o_next_state (w_lfsr_adv)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_good  <= '0;
         r_miss  <= '0;
         r_lfsr  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_good  <= w_good_nxt;
         r_miss  <= w_miss_nxt;
         r_lfsr  <= w_lfsr_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_good_nxt  = r_good;
      w_miss_nxt  = r_miss;
      w_lfsr_nxt  = r_lfsr;
      w_count     = 1'b0;
      w_word_err  = 1'b0;
      w_lost      = 1'b0;
      if (!enable) begin
         w_state_nxt = IDLE;
         w_good_nxt  = '0;
         w_miss_nxt  = '0;
      end else begin
         case (r_state)
            IDLE: begin
               w_state_nxt = HUNT;
               w_good_nxt  = '0;
               w_miss_nxt  = '0;
            end
            HUNT: if (r_s1_valid) begin
               if (w_mismatch) begin
                  w_good_nxt = '0;
               end else begin
                  w_lfsr_nxt = w_lfsr_adv;
                  if (r_good + 4'd1 == c_LOCK) begin
                     w_state_nxt = LOCKED;
                     w_good_nxt  = '0;
                     w_miss_nxt  = '0;
                  end else begin
                     w_good_nxt = r_good + 4'd1;
                  end
               end
            end
            LOCKED: if (r_s1_valid) begin
               w_lfsr_nxt = w_lfsr_adv;
               w_count    = 1'b1;
               w_word_err = w_mismatch;
               if (!w_mismatch) begin
                  w_miss_nxt = '0;
               end else if (r_miss + 4'd1 == c_MISS) begin
                  w_state_nxt = HUNT;
                  w_good_nxt  = '0;
                  w_miss_nxt  = '0;
                  w_lost      = 1'b1;
               end else begin
                  w_miss_nxt = r_miss + 4'd1;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_data   <= '0;
         r_word_err  <= 1'b0;
         r_lock_lost <= 1'b0;
         r_s3_count  <= 1'b0;
         r_s3_err    <= 1'b0;
         r_s3_vec    <= '0;
      end else begin
         r_s1_valid  <= in_valid & enable;
         r_s1_data   <= in_data;
         r_word_err  <= w_word_err;
         r_lock_lost <= w_lost;
         r_s3_count  <= w_count;
         r_s3_err    <= w_word_err;
         r_s3_vec    <= w_count ? w_err_vec : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word_cnt     <= '0;
         r_word_err_cnt <= '0;
         r_bit_err_cnt  <= '0;
      end else if (clear) begin
         r_word_cnt     <= '0;
         r_word_err_cnt <= '0;
         r_bit_err_cnt  <= '0;
      end else if (r_s3_count) begin
         r_word_cnt     <= sat_add(r_word_cnt, c_PC_W'(1'b1));
         r_word_err_cnt <= sat_add(r_word_err_cnt, c_PC_W'(r_s3_err));
         r_bit_err_cnt  <= sat_add(r_bit_err_cnt, popcount(r_s3_vec));
      end
   end

   assign locked       = (r_state == LOCKED);
   assign word_err     = r_word_err;
   assign lock_lost    = r_lock_lost;
   assign word_cnt     = r_word_cnt;
   assign word_err_cnt = r_word_err_cnt;
   assign bit_err_cnt  = r_bit_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_example_hmc_prbs_checker.sv
// ============================================================================
//  Module   : tb_example_hmc_prbs_checker
//  Purpose  : Bench for the PRBS checker against a bit-sequence reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_example_hmc_prbs_checker;

   localparam logic [14:0] POLY   = 15'b100000000000011;
   localparam int          LOCK   = 4;
   localparam int          MISS   = 4;
   localparam longint      CMAX   = 64'h0000_0000_FFFF_FFFF;
   localparam int          M_IDLE = 0;
   localparam int          M_HUNT = 1;
   localparam int          M_LOCK = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        enable = 1'b0;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic [47:0] in_data = '0;

   logic        locked, word_err, lock_lost;
   logic [31:0] word_cnt, word_err_cnt, bit_err_cnt;
   logic        s_locked, s_word_err, s_lock_lost;
   logic [3:0]  s_word_cnt, s_word_err_cnt, s_bit_err_cnt;

   example_hmc_prbs_checker dut (
      .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
      .in_valid(in_valid), .in_data(in_data),
      .locked(locked), .word_err(word_err), .lock_lost(lock_lost),
      .word_cnt(word_cnt), .word_err_cnt(word_err_cnt), .bit_err_cnt(bit_err_cnt)
   );

   example_hmc_prbs_checker #(.MISS_LIMIT(15), .CNT_W(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear),
      .in_valid(in_valid), .in_data(in_data),
      .locked(s_locked), .word_err(s_word_err), .lock_lost(s_lock_lost),
      .word_cnt(s_word_cnt), .word_err_cnt(s_word_err_cnt), .bit_err_cnt(s_bit_err_cnt)
   );

   always #5 clk = ~clk;

   int          vectors = 0;
   int          miscompares = 0;
   int          m_st, m_good, m_miss, p_cnt, p_werr, p_bits;
   logic [14:0] m_s, gen_state;
   logic        m_s1v, m_werr, m_lost;
   logic [47:0] m_s1d;
   longint      m_wc, m_wec, m_bec;
   int          sat_lost_seen, sat_err_seen;

   // PRBS bit stream: b[n] = XOR of tapped bits among the previous 15.
   function automatic logic [62:0] extend(input logic [14:0] seed);
      logic [62:0] b;
      logic        x;
      b = '0;
      b[14:0] = seed;
      for (int n = 15; n < 63; n++) begin
         x = 1'b0;
         for (int k = 0; k < 15; k++) if (POLY[k]) x = x ^ b[n-15+k];
         b[n] = x;
      end
      return b;
   endfunction

   function automatic longint sat(input longint v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_st = M_IDLE; m_good = 0; m_miss = 0; m_s = '0;
      m_s1v = 1'b0; m_s1d = '0; m_werr = 1'b0; m_lost = 1'b0;
      p_cnt = 0; p_werr = 0; p_bits = 0;
      m_wc = 0; m_wec = 0; m_bec = 0;
   endtask

   task automatic model_edge();
      logic [62:0] e;
      logic [47:0] diff;
      logic [14:0] seed;
      if (clear) begin
         m_wc = 0; m_wec = 0; m_bec = 0;
      end else if (p_cnt != 0) begin
         m_wc  = sat(m_wc + 1);
         m_wec = sat(m_wec + p_werr);
         m_bec = sat(m_bec + p_bits);
      end
      m_werr = 1'b0; m_lost = 1'b0; p_cnt = 0; p_werr = 0; p_bits = 0;
      if (!enable) begin
         m_st = M_IDLE; m_good = 0; m_miss = 0;
      end else if (m_st == M_IDLE) begin
         m_st = M_HUNT; m_good = 0; m_miss = 0;
      end else if (m_s1v) begin
         seed = (m_st == M_HUNT && m_good == 0) ? m_s1d[14:0] : m_s;
         e    = extend(seed);
         diff = m_s1d ^ e[47:0];
         if (m_st == M_HUNT) begin
            if (diff != 0) m_good = 0;
            else begin
               m_s = e[62:48];
               m_good++;
               if (m_good == LOCK) begin m_st = M_LOCK; m_good = 0; m_miss = 0; end
            end
         end else begin
            m_s = e[62:48];
            p_cnt = 1; p_bits = $countones(diff); p_werr = int'(diff != 0);
            m_werr = (diff != 0);
            if (diff == 0) m_miss = 0;
            else begin
               m_miss++;
               if (m_miss == MISS) begin m_st = M_HUNT; m_good = 0; m_miss = 0; m_lost = 1'b1; end
            end
         end
      end
      m_s1v = in_valid & enable;
      m_s1d = in_data;
   endtask

   task automatic check_all();
      chk("locked", 64'(locked), 64'(m_st == M_LOCK));
      chk("word_err", 64'(word_err), 64'(m_werr));
      chk("lock_lost", 64'(lock_lost), 64'(m_lost));
      chk("word_cnt", 64'(word_cnt), m_wc);
      chk("word_err_cnt", 64'(word_err_cnt), m_wec);
      chk("bit_err_cnt", 64'(bit_err_cnt), m_bec);
   endtask

   task automatic cyc();
      @(posedge clk);
      if (rst_n) model_edge();
      @(negedge clk);
      sat_lost_seen += int'(s_lock_lost);
      sat_err_seen  += int'(s_word_err);
      check_all();
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) cyc();
   endtask

   task automatic gen_word(output logic [47:0] w);
      logic [62:0] e;
      e = extend(gen_state);
      w = e[47:0];
      gen_state = e[62:48];
   endtask

   task automatic send(input logic [47:0] flip);
      logic [47:0] w;
      gen_word(w);
      in_valid = 1'b1;
      in_data  = w ^ flip;
      cyc();
   endtask

   initial begin
      logic [47:0] m, w;
      int          first_lock, p1, p2;
      sat_lost_seen = 0; sat_err_seen = 0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();

      rst_n = 1'b1; enable = 1'b1;
      idle(3);

      // 1: clean stream from seed 1
      gen_state = 15'h0001;
      first_lock = -1;
      for (int i = 0; i < 20; i++) begin
         send('0);
         if (first_lock < 0 && locked === 1'b1) first_lock = i;
      end
      idle(3);
      chk("t1_lock_latency", 64'(first_lock), 64'd4);
      chk("t1_word_cnt", 64'(word_cnt), 64'd16);
      chk("t1_word_err_cnt", 64'(word_err_cnt), 64'd0);

      // 2: single flipped bit
      m = '0; m[20] = 1'b1;
      send(m);
      idle(3);
      chk("t2_bit_err_cnt", 64'(bit_err_cnt), 64'd1);
      chk("t2_word_err_cnt", 64'(word_err_cnt), 64'd1);
      chk("t2_locked", 64'(locked), 64'd1);

      // 3: flips including seed bits; following words stay clean
      m = '0; m[0] = 1'b1; m[7] = 1'b1; m[47] = 1'b1;
      send(m);
      repeat (3) send('0);
      idle(3);
      chk("t3_bit_err_cnt", 64'(bit_err_cnt), 64'd4);
      chk("t3_word_err_cnt", 64'(word_err_cnt), 64'd2);
      chk("t3_word_cnt", 64'(word_cnt), 64'd21);

      // 4: four random words drop lock, clean stream relocks
      for (int i = 0; i < 4; i++) begin
         gen_word(w);
         in_valid = 1'b1;
         in_data  = {$urandom(), $urandom()};
         cyc();
      end
      repeat (8) send('0);
      idle(3);
      chk("t4_word_err_cnt", 64'(word_err_cnt), 64'd6);
      chk("t4_locked", 64'(locked), 64'd1);
      chk("t4_sat_locked", 64'(s_locked), 64'd1);

      // 5: saturation on the 4-bit instance
      clear = 1'b1; idle(1); clear = 1'b0;
      sat_lost_seen = 0; sat_err_seen = 0;
      for (int i = 0; i < 20; i++) begin
         p1 = $urandom_range(0, 47);
         p2 = (p1 + 1 + $urandom_range(0, 46)) % 48;
         m = '0; m[p1] = 1'b1; m[p2] = 1'b1;
         send(m);
      end
      idle(3);
      chk("t5_sat_word_err_cnt", 64'(s_word_err_cnt), 64'd15);
      chk("t5_sat_bit_err_cnt", 64'(s_bit_err_cnt), 64'd15);
      chk("t5_sat_word_cnt", 64'(s_word_cnt), 64'd15);
      chk("t5_sat_locked", 64'(s_locked), 64'd0);
      chk("t5_sat_lost_pulses", 64'(sat_lost_seen), 64'd1);
      chk("t5_sat_err_pulses", 64'(sat_err_seen), 64'd15);
      repeat (8) send('0);
      idle(3);

      // 6: sparse traffic with clear and asynchronous reset mid-stream
      for (int i = 0; i < 80; i++) begin
         if (i == 50) begin
            rst_n = 1'b0;
            model_reset();
            #1;
            check_all();
            idle(2);
            rst_n = 1'b1;
         end
         clear = (i == 25);
         if ($urandom_range(0, 1) == 1) begin
            gen_word(w);
            in_valid = 1'b1;
            in_data  = w;
         end else begin
            in_valid = 1'b0;
         end
         cyc();
      end
      clear = 1'b0;
      repeat (6) send('0);
      idle(3);
      chk("t6_locked", 64'(locked), 64'd1);
      chk("t6_word_err_cnt", 64'(word_err_cnt), 64'd0);
      chk("t6_bit_err_cnt", 64'(bit_err_cnt), 64'd0);

      // 7: disable returns to idle
      enable = 1'b0;
      idle(2);
      chk("t7_locked", 64'(locked), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
